bcdtosev: RTL and testbench
===========================

BCDTOSEV -- requirements
Module: bcdtosev

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 0: 0 drives lit segments as 1, 1 inverts every sev_out bit, for common-anode displays.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 bcd_in  input  4  BCD digit to display.
REQ-005 lamp_test  input  1  force all seven segments lit.
REQ-006 blank  input  1  force all segments dark.
REQ-007 rb_in  input  1  ripple-blank in; suppress display of digit 0.
REQ-008 sev_out  output  7  registered segments {a,b,c,d,e,f,g}; bit 6 is a, bit 0 is g.
REQ-009 rb_out  output  1  registered ripple-blank out.
REQ-010 err  output  1  registered flag: the last sampled bcd_in was 10..15.

Function
REQ-011 Outputs SHALL be registered with exactly 1 cycle latency: the value sampled at edge N appears after edge N, with no combinational input-to-output path.
REQ-012 Active-high glyphs SHALL be:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
REQ-013 Priority per cycle SHALL be, highest first: lamp_test (1111111), then blank (0000000), then invalid code, then ripple blank, then the REQ-012 glyph.
REQ-014 Invalid code 10..15, without the macro in REQ-024, SHALL give sev_out=0000000 and err=1.
REQ-015 err SHALL be computed from bcd_in regardless of lamp_test or blank.
REQ-016 Ripple blank: when rb_in=1 and bcd_in=0 and neither lamp_test nor blank is set, sev_out SHALL be 0000000 and rb_out=1; otherwise rb_out SHALL be 0.
REQ-017 rb_out SHALL be 0 whenever lamp_test=1 or blank=1.
REQ-018 When SEG_ACTIVE_LOW=1, the final sev_out value, including reset value and lamp test, SHALL be bitwise inverted; rb_out and err SHALL NOT be inverted.
REQ-019 Inputs SHALL be treated as synchronous to clk; the block applies no input synchronisation.

Reset
REQ-020 While rst_n=0 at a rising edge:
- sev_out SHALL take the dark pattern: 0000000, or 1111111 when SEG_ACTIVE_LOW=1.
- rb_out SHALL be 0 and err SHALL be 0.
REQ-021 Reset SHALL take priority over every input, including lamp_test.
REQ-022 On the first edge with rst_n=1, the block SHALL resume decoding; the first valid output appears after that edge.
REQ-023 Asserting reset mid-stream SHALL discard the pending value with no partial output.

Configuration
REQ-024 When macro BCDTOSEV_HEX_EN is defined, codes 10..15 SHALL display A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-025 With BCDTOSEV_HEX_EN defined, err SHALL still be 1 for codes 10..15.
REQ-026 When BCDTOSEV_HEX_EN is undefined, codes 10..15 SHALL follow REQ-014 and the hex glyph table SHALL NOT be compiled in.

Structure
REQ-027 Package bcdtosev_pkg SHALL hold:
- the 7-bit segment typedef
- glyph constants for 0..9 and A..F
- constants SEG_DARK and SEG_ALL
REQ-028 Sub-module bcdtosev_dec SHALL be a purely combinational 4-bit-to-glyph lookup with a valid output, instantiated once.
REQ-029 Priority muxing, polarity inversion and registers SHALL live in bcdtosev.

Verification
REQ-030 Reset: rst_n=0 for 2 edges, bcd_in=8, lamp_test=1 -> sev_out=0000000, err=0, rb_out=0.
REQ-031 Decode sweep: bcd_in=0,1,2,4,9 on successive edges -> one cycle later sev_out=1111110, 0110000, 1101101, 0110011, 1111011, with err=0.
REQ-032 Invalid code: bcd_in=1010 -> without BCDTOSEV_HEX_EN sev_out=0000000, err=1; with it sev_out=1110111, err=1.
REQ-033 Ripple blank:
- rb_in=1, bcd_in=0 -> sev_out=0000000, rb_out=1.
- rb_in=1, bcd_in=5 -> sev_out=1011011, rb_out=0.
REQ-034 Priority: lamp_test=1, blank=1, bcd_in=12 -> sev_out=1111111, err=1, rb_out=0.
REQ-035 Polarity: SEG_ACTIVE_LOW=1, bcd_in=1 -> sev_out=1001111; in reset -> sev_out=1111111.

Source files
------------

// File: rtl/bcdtosev_pkg.sv
// Shared types and glyph constants for the BCD to seven-segment decoder.
// Segment order is {a,b,c,d,e,f,g}: bit 6 is a, bit 0 is g, active-high.
package bcdtosev_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_DARK = 7'b0000000;
   localparam seg_t SEG_ALL  = 7'b1111111;

   localparam seg_t GLYPH_0 = 7'b1111110;
   localparam seg_t GLYPH_1 = 7'b0110000;
   localparam seg_t GLYPH_2 = 7'b1101101;
   localparam seg_t GLYPH_3 = 7'b1111001;
   localparam seg_t GLYPH_4 = 7'b0110011;
   localparam seg_t GLYPH_5 = 7'b1011011;
   localparam seg_t GLYPH_6 = 7'b1011111;
   localparam seg_t GLYPH_7 = 7'b1110000;
   localparam seg_t GLYPH_8 = 7'b1111111;
   localparam seg_t GLYPH_9 = 7'b1111011;

   localparam seg_t GLYPH_A = 7'b1110111;
   localparam seg_t GLYPH_B = 7'b0011111;
   localparam seg_t GLYPH_C = 7'b1001110;
   localparam seg_t GLYPH_D = 7'b0111101;
   localparam seg_t GLYPH_E = 7'b1001111;
   localparam seg_t GLYPH_F = 7'b1000111;

endpackage

// File: rtl/bcdtosev_dec.sv
// Combinational 4-bit code to active-high glyph lookup.
// o_valid is high for codes 0..9 only. Codes 10..15 give hex letters when
// BCDTOSEV_HEX_EN is defined, otherwise the dark pattern.
module bcdtosev_dec
   import bcdtosev_pkg::*;
(
   input  logic [3:0] i_code,
   output seg_t       o_glyph,
   output logic       o_valid
);

   // Glyph lookup and BCD range flag.
   always_comb begin
      o_glyph = SEG_DARK;
      o_valid = 1'b1;
      case (i_code)
         4'd0: o_glyph = GLYPH_0;
         4'd1: o_glyph = GLYPH_1;
         4'd2: o_glyph = GLYPH_2;
         4'd3: o_glyph = GLYPH_3;
         4'd4: o_glyph = GLYPH_4;
         4'd5: o_glyph = GLYPH_5;
         4'd6: o_glyph = GLYPH_6;
         4'd7: o_glyph = GLYPH_7;
         4'd8: o_glyph = GLYPH_8;
         4'd9: o_glyph = GLYPH_9;
`ifdef BCDTOSEV_HEX_EN
         4'd10: begin o_glyph = GLYPH_A; o_valid = 1'b0; end
         4'd11: begin o_glyph = GLYPH_B; o_valid = 1'b0; end
         4'd12: begin o_glyph = GLYPH_C; o_valid = 1'b0; end
         4'd13: begin o_glyph = GLYPH_D; o_valid = 1'b0; end
         4'd14: begin o_glyph = GLYPH_E; o_valid = 1'b0; end
         4'd15: begin o_glyph = GLYPH_F; o_valid = 1'b0; end
`else
         default: begin
            o_glyph = SEG_DARK;
            o_valid = 1'b0;
         end
`endif
      endcase
   end

endmodule

// File: rtl/bcdtosev.sv
// Registered BCD to seven-segment decoder with lamp test, blanking and
// ripple-blank chaining. Optional macro BCDTOSEV_HEX_EN shows A..F for
// codes 10..15 instead of dark; err still flags those codes either way.
module bcdtosev
   import bcdtosev_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] bcd_in,
   input  logic       lamp_test,
   input  logic       blank,
   input  logic       rb_in,
   output logic [6:0] sev_out,
   output logic       rb_out,
   output logic       err
);

   // Dark pattern as seen on the pins, after polarity.
   localparam seg_t SEG_RST = SEG_ACTIVE_LOW ? SEG_ALL : SEG_DARK;

   seg_t w_glyph;
   logic w_valid;
   logic w_zero_blank;
   seg_t w_seg;
   seg_t w_seg_pol;

   seg_t r_sev;
   logic r_rb;
   logic r_err;

   bcdtosev_dec u_dec (
      .i_code  (bcd_in),
      .o_glyph (w_glyph),
      .o_valid (w_valid)
   );

   assign w_zero_blank = rb_in && (bcd_in == 4'd0) && !lamp_test && !blank;

   // Per-cycle priority: lamp test, blank, invalid code, ripple blank, glyph.
   always_comb begin
      w_seg = SEG_DARK;
      if (lamp_test) begin
         w_seg = SEG_ALL;
      end else if (blank) begin
         w_seg = SEG_DARK;
      end else if (!w_valid) begin
         // Decoder already returns dark here unless hex letters are enabled.
         w_seg = w_glyph;
      end else if (w_zero_blank) begin
         w_seg = SEG_DARK;
      end else begin
         w_seg = w_glyph;
      end
   end

   assign w_seg_pol = SEG_ACTIVE_LOW ? ~w_seg : w_seg;

   // Output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sev <= SEG_RST;
         r_rb  <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_sev <= w_seg_pol;
         r_rb  <= w_zero_blank;
         r_err <= !w_valid;
      end
   end

   assign sev_out = r_sev;
   assign rb_out  = r_rb;
   assign err     = r_err;

endmodule

// File: tb/tb_bcdtosev.sv
// Self-checking bench for bcdtosev: one active-high and one active-low
// instance share stimulus; expected values are hand-written glyph constants.
module tb_bcdtosev;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] bcd_in;
   logic       lamp_test;
   logic       blank;
   logic       rb_in;
   logic [6:0] sev_hi, sev_lo;
   logic       rb_hi, rb_lo, err_hi, err_lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcdtosev #(.SEG_ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk       (clk),
      .rst_n     (rst_n),
      .bcd_in    (bcd_in),
      .lamp_test (lamp_test),
      .blank     (blank),
      .rb_in     (rb_in),
      .sev_out   (sev_hi),
      .rb_out    (rb_hi),
      .err       (err_hi)
   );

   bcdtosev #(.SEG_ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk       (clk),
      .rst_n     (rst_n),
      .bcd_in    (bcd_in),
      .lamp_test (lamp_test),
      .blank     (blank),
      .rb_in     (rb_in),
      .sev_out   (sev_lo),
      .rb_out    (rb_lo),
      .err       (err_lo)
   );

   typedef struct {
      string      name;
      logic [3:0] bcd;
      logic       lt;
      logic       bl;
      logic       rb;
      logic [6:0] exp_sev;
      logic       exp_rb;
      logic       exp_err;
   } vec_t;

   vec_t vecs[32];
   int   nvec = 0;

   task automatic add(input string name, input logic [3:0] bcd, input logic lt,
                      input logic bl, input logic rb, input logic [6:0] sev,
                      input logic exp_rb, input logic exp_err);
      vecs[nvec] = '{name, bcd, lt, bl, rb, sev, exp_rb, exp_err};
      nvec++;
   endtask

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Checks both instances against one active-high expectation.
   task automatic chk_all(input string name, input logic [6:0] sev, input logic rb,
                          input logic er);
      chk({name, ".sev"}, sev_hi, sev);
      chk({name, ".sev_lo"}, sev_lo, ~sev);
      chk({name, ".rb"}, {6'd0, rb_hi}, {6'd0, rb});
      chk({name, ".rb_lo"}, {6'd0, rb_lo}, {6'd0, rb});
      chk({name, ".err"}, {6'd0, err_hi}, {6'd0, er});
      chk({name, ".err_lo"}, {6'd0, err_lo}, {6'd0, er});
   endtask

   task automatic drive(input logic rn, input logic [3:0] bcd, input logic lt,
                        input logic bl, input logic rb);
      @(negedge clk);
      rst_n     = rn;
      bcd_in    = bcd;
      lamp_test = lt;
      blank     = bl;
      rb_in     = rb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] hex_tbl[6];
      logic [6:0] inv_exp;
      string      nm;

`ifdef BCDTOSEV_HEX_EN
      hex_tbl = '{7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`else
      hex_tbl = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
`endif

      // Decode sweep on successive edges, then the rest of the digits.
      add("d0", 4'd0, 0, 0, 0, 7'b1111110, 0, 0);
      add("d1", 4'd1, 0, 0, 0, 7'b0110000, 0, 0);
      add("d2", 4'd2, 0, 0, 0, 7'b1101101, 0, 0);
      add("d4", 4'd4, 0, 0, 0, 7'b0110011, 0, 0);
      add("d9", 4'd9, 0, 0, 0, 7'b1111011, 0, 0);
      add("d3", 4'd3, 0, 0, 0, 7'b1111001, 0, 0);
      add("d5", 4'd5, 0, 0, 0, 7'b1011011, 0, 0);
      add("d6", 4'd6, 0, 0, 0, 7'b1011111, 0, 0);
      add("d7", 4'd7, 0, 0, 0, 7'b1110000, 0, 0);
      add("d8", 4'd8, 0, 0, 0, 7'b1111111, 0, 0);
      // Invalid codes.
      for (int c = 10; c < 16; c++) begin
         nm = $sformatf("inv%0d", c);
         add(nm, 4'(c), 0, 0, 0, hex_tbl[c-10], 0, 1);
      end
      // Ripple blank.
      add("rb_zero", 4'd0, 0, 0, 1, 7'b0000000, 1, 0);
      add("rb_five", 4'd5, 0, 0, 1, 7'b1011011, 0, 0);
      add("rb_inv", 4'd10, 0, 0, 1, hex_tbl[0], 0, 1);
      // Priority.
      add("lt_bl_12", 4'd12, 1, 1, 0, 7'b1111111, 0, 1);
      add("lt_rb0", 4'd0, 1, 0, 1, 7'b1111111, 0, 0);
      add("bl_8", 4'd8, 0, 1, 0, 7'b0000000, 0, 0);
      add("bl_rb0", 4'd0, 0, 1, 1, 7'b0000000, 0, 0);
      add("bl_15", 4'd15, 0, 1, 0, 7'b0000000, 0, 1);
      add("d1_again", 4'd1, 0, 0, 0, 7'b0110000, 0, 0);

      // Reset dominates lamp test; outputs dark.
      drive(0, 4'd8, 1, 0, 0);
      drive(0, 4'd8, 1, 0, 0);
      chk_all("reset", 7'b0000000, 0, 0);

      for (int i = 0; i < nvec; i++) begin
         drive(1, vecs[i].bcd, vecs[i].lt, vecs[i].bl, vecs[i].rb);
         chk_all(vecs[i].name, vecs[i].exp_sev, vecs[i].exp_rb, vecs[i].exp_err);
      end

      // Mid-stream reset discards the pending value, then decoding resumes.
      drive(1, 4'd8, 0, 0, 0);
      chk_all("pre_rst8", 7'b1111111, 0, 0);
      drive(0, 4'd3, 0, 0, 0);
      chk_all("mid_rst", 7'b0000000, 0, 0);
      drive(0, 4'd12, 1, 0, 0);
      chk_all("mid_rst_err", 7'b0000000, 0, 0);
      drive(1, 4'd3, 0, 0, 0);
      chk_all("resume3", 7'b1111001, 0, 0);

      // Output holds one-cycle latency: input change between edges is not visible.
      @(negedge clk);
      bcd_in = 4'd7;
      #1;
      chk("latency_hold", sev_hi, 7'b1111001);
      @(posedge clk);
      #1;
      chk("latency_upd", sev_hi, 7'b1110000);

      inv_exp = hex_tbl[2];
      drive(1, 4'd12, 0, 0, 1);
      chk_all("inv12_rb", inv_exp, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
